// File: rtl/dl11_pkg.sv
// dl11_pkg: shared constants and state types for the DL11 serial port.
//   - REG_*   : register index decoded from bus_addr[2:1]
//   - CSR_* / RBUF_* : bit positions inside the CSR and RBUF words
//   - tx_state_t / rx_state_t : transmitter and receiver FSM states
package dl11_pkg;

    localparam logic [1:0] REG_RCSR = 2'd0;
    localparam logic [1:0] REG_RBUF = 2'd1;
    localparam logic [1:0] REG_XCSR = 2'd2;
    localparam logic [1:0] REG_XBUF = 2'd3;

    localparam int unsigned CSR_DONE_READY = 7;
    localparam int unsigned CSR_IE         = 6;
    localparam int unsigned CSR_MAINT      = 2;
    localparam int unsigned RBUF_ERR       = 15;
    localparam int unsigned RBUF_OVR       = 14;
    localparam int unsigned RBUF_FRM       = 13;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/dl11_uart_rx.sv
// dl11_uart_rx: 8N1 receiver with a 2-FF input synchronizer.
// Ports:
//   clk_sys, reset_n  : clock, synchronous active-low reset
//   uart_rxd          : asynchronous serial input
//   i_lb_sel          : 1 = receive from i_lb_line (internal loopback) instead of uart_rxd
//   i_lb_line         : internal TX serial stream
//   rx_valid          : one-cycle pulse when a frame completes
//   rx_data           : received byte (valid with rx_valid)
//   rx_frm            : stop bit was 0 for the frame just completed
module dl11_uart_rx
    import dl11_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 417
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       uart_rxd,
    input  logic       i_lb_sel,
    input  logic       i_lb_line,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frm
);

    localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

    logic        r_sync1, r_sync2, r_prev;
    rx_state_t   r_state, w_state_d;
    logic [15:0] r_cnt, w_cnt_d;
    logic [2:0]  r_bit, w_bit_d;
    logic [7:0]  r_shift, w_shift_d;
    logic        r_valid, w_valid_d;
    logic        r_frm, w_frm_d;
    logic        w_line;

    assign w_line = i_lb_sel ? i_lb_line : r_sync2;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 16'd1;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_valid_d = 1'b0;
        w_frm_d   = r_frm;
        case (r_state)
            RX_IDLE: begin
                w_cnt_d = '0;
                if (r_prev && !w_line) w_state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit check rejects short glitches.
                if (r_cnt == HALF_M1) begin
                    w_cnt_d = '0;
                    if (w_line) begin
                        w_state_d = RX_IDLE;
                    end else begin
                        w_state_d = RX_DATA;
                        w_bit_d   = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (r_cnt == DIV_M1) begin
                    w_cnt_d   = '0;
                    w_shift_d = {w_line, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_d = RX_STOP;
                    else               w_bit_d   = r_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (r_cnt == DIV_M1) begin
                    w_cnt_d   = '0;
                    w_state_d = RX_IDLE;
                    w_valid_d = 1'b1;
                    w_frm_d   = ~w_line;
                end
            end
            default: w_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_frm   <= 1'b0;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= w_line;
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_valid <= w_valid_d;
            r_frm   <= w_frm_d;
        end
    end

    assign rx_valid = r_valid;
    assign rx_data  = r_shift;
    assign rx_frm   = r_frm;

endmodule

// File: rtl/dl11_serial.sv
// dl11_serial: DL11-compatible serial port, VM1 MPI bus responder (4-word window at BASE_ADDR).
// Ports:
//   clk_sys, reset_n, ce         : clock, synchronous active-low reset, bus clock enable
//   bus_addr/din/sync/stb/we/wtbt: CPU cycle from the initiator
//   bus_dout, bus_ack            : read data (0 when not selected) and reply
//   irq_rx_req/ack, irq_tx_req/ack : interrupt request/acknowledge pairs to the vic
//   uart_rxd, uart_txd           : serial input (async) and output (idle 1)
// Optional: define DL11_MAINT_EN to enable XCSR MAINT (internal TX->RX loopback).
module dl11_serial
    import dl11_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = 417,
    parameter logic [15:0] BASE_ADDR = 16'o177560
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_din,
    input  logic        bus_sync,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [1:0]  bus_wtbt,
    output logic [15:0] bus_dout,
    output logic        bus_ack,
    output logic        irq_rx_req,
    input  logic        irq_rx_ack,
    output logic        irq_tx_req,
    input  logic        irq_tx_ack,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam logic [15:0] DIV_M1 = 16'(BAUD_DIV - 1);

    // Bus decode
    logic       w_sel, w_act, w_rise, w_wr, w_rd;
    logic [1:0] w_reg;
    logic       w_wr_rcsr, w_wr_xcsr, w_xbuf_load, w_rd_rbuf;
    logic       r_act_q, r_ack;
    logic [15:0] w_rdata, r_snap;

    // Register state
    logic       r_done, r_rx_ie, r_ovr, r_frm;
    logic [7:0] r_rbuf;
    logic       r_ready, r_tx_ie;
    logic       w_maint;
    logic       r_rx_lvl_q, r_tx_lvl_q, r_rx_req, r_tx_req;
    logic       w_rx_lvl, w_tx_lvl;

    // TX
    tx_state_t   r_tx_state, w_tx_state_d;
    logic [15:0] r_tx_cnt, w_tx_cnt_d;
    logic [2:0]  r_tx_bit, w_tx_bit_d;
    logic [7:0]  r_tx_buf;
    logic        w_tx_line, w_tx_done, w_tx_end;

    // RX
    logic       w_rx_valid, w_rx_frm;
    logic [7:0] w_rx_data;

    logic w_unused;
    assign w_unused = ^{bus_addr[0], bus_din[15:8], bus_wtbt[1]};

    assign w_sel  = bus_sync & (bus_addr[15:3] == BASE_ADDR[15:3]);
    assign w_reg  = bus_addr[2:1];
    assign w_act  = w_sel & bus_stb;
    assign w_rise = w_act & ~r_act_q;
    assign w_wr   = w_rise & bus_we;
    assign w_rd   = w_rise & ~bus_we;

    assign w_wr_rcsr   = w_wr & (w_reg == REG_RCSR) & bus_wtbt[0];
    assign w_wr_xcsr   = w_wr & (w_reg == REG_XCSR) & bus_wtbt[0];
    assign w_xbuf_load = w_wr & (w_reg == REG_XBUF) & bus_wtbt[0] & r_ready;
    assign w_rd_rbuf   = w_rd & (w_reg == REG_RBUF);

`ifdef DL11_MAINT_EN
    logic r_maint;
    always_ff @(posedge clk_sys) begin
        if (!reset_n)       r_maint <= 1'b0;
        else if (w_wr_xcsr) r_maint <= bus_din[CSR_MAINT];
    end
    assign w_maint  = r_maint;
    assign uart_txd = r_maint ? 1'b1 : w_tx_line;
`else
    assign w_maint  = 1'b0;
    assign uart_txd = w_tx_line;
`endif

    always_comb begin
        w_rdata = '0;
        unique case (w_reg)
            REG_RCSR: begin
                w_rdata[CSR_DONE_READY] = r_done;
                w_rdata[CSR_IE]         = r_rx_ie;
            end
            REG_RBUF: begin
                w_rdata[7:0]     = r_rbuf;
                w_rdata[RBUF_ERR] = r_ovr | r_frm;
                w_rdata[RBUF_OVR] = r_ovr;
                w_rdata[RBUF_FRM] = r_frm;
            end
            REG_XCSR: begin
                w_rdata[CSR_DONE_READY] = r_ready;
                w_rdata[CSR_IE]         = r_tx_ie;
                w_rdata[CSR_MAINT]      = w_maint;
            end
            REG_XBUF: w_rdata = '0;
        endcase
    end

    // Data is latched at the strobe edge so the RBUF read-clear does not alter what the CPU samples.
    assign bus_dout = (w_act && !bus_we) ? (r_act_q ? r_snap : w_rdata) : 16'h0000;
    assign bus_ack  = r_ack;

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt + 16'd1;
        w_tx_bit_d   = r_tx_bit;
        w_tx_done    = 1'b0;
        w_tx_line    = 1'b1;
        w_tx_end     = (r_tx_cnt == DIV_M1);
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_d = '0;
                if (w_xbuf_load) w_tx_state_d = TX_START;
            end
            TX_START: begin
                w_tx_line = 1'b0;
                if (w_tx_end) begin
                    w_tx_cnt_d   = '0;
                    w_tx_bit_d   = 3'd0;
                    w_tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                w_tx_line = r_tx_buf[r_tx_bit];
                if (w_tx_end) begin
                    w_tx_cnt_d = '0;
                    if (r_tx_bit == 3'd7) w_tx_state_d = TX_STOP;
                    else                  w_tx_bit_d   = r_tx_bit + 3'd1;
                end
            end
            TX_STOP: begin
                if (w_tx_end) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = TX_IDLE;
                    w_tx_done    = 1'b1;
                end
            end
            default: w_tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else begin
            r_tx_state <= w_tx_state_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_bit   <= w_tx_bit_d;
        end
    end

    dl11_uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .uart_rxd  (uart_rxd),
        .i_lb_sel  (w_maint),
        .i_lb_line (w_tx_line),
        .rx_valid  (w_rx_valid),
        .rx_data   (w_rx_data),
        .rx_frm    (w_rx_frm)
    );

    assign w_rx_lvl = r_done & r_rx_ie;
    assign w_tx_lvl = r_ready & r_tx_ie;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_act_q    <= 1'b0;
            r_ack      <= 1'b0;
            r_snap     <= '0;
            r_rx_ie    <= 1'b0;
            r_tx_ie    <= 1'b0;
            r_ready    <= 1'b1;
            r_tx_buf   <= '0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_frm      <= 1'b0;
            r_rbuf     <= '0;
            r_rx_lvl_q <= 1'b0;
            r_tx_lvl_q <= 1'b0;
            r_rx_req   <= 1'b0;
            r_tx_req   <= 1'b0;
        end else begin
            r_act_q <= w_act;
            if (w_rise) r_snap <= w_rdata;
            if (!bus_stb)          r_ack <= 1'b0;
            else if (ce && w_act)  r_ack <= 1'b1;

            if (w_wr_rcsr) r_rx_ie <= bus_din[CSR_IE];
            if (w_wr_xcsr) r_tx_ie <= bus_din[CSR_IE];

            if (w_xbuf_load) begin
                r_tx_buf <= bus_din[7:0];
                r_ready  <= 1'b0;
            end else if (w_tx_done) begin
                r_ready  <= 1'b1;
            end

            // A byte arriving with a concurrent RBUF read wins: fresh DONE, no overrun.
            if (w_rx_valid) begin
                r_rbuf <= w_rx_data;
                r_done <= 1'b1;
                if (w_rd_rbuf) begin
                    r_ovr <= 1'b0;
                    r_frm <= w_rx_frm;
                end else begin
                    r_ovr <= r_ovr | r_done;
                    r_frm <= r_frm | w_rx_frm;
                end
            end else if (w_rd_rbuf) begin
                r_done <= 1'b0;
                r_ovr  <= 1'b0;
                r_frm  <= 1'b0;
            end

            r_rx_lvl_q <= w_rx_lvl;
            r_tx_lvl_q <= w_tx_lvl;
            if (!w_rx_lvl)                r_rx_req <= 1'b0;
            else if (!r_rx_lvl_q)         r_rx_req <= 1'b1;
            else if (irq_rx_ack)          r_rx_req <= 1'b0;
            if (!w_tx_lvl)                r_tx_req <= 1'b0;
            else if (!r_tx_lvl_q)         r_tx_req <= 1'b1;
            else if (irq_tx_ack)          r_tx_req <= 1'b0;
        end
    end

    assign irq_rx_req = r_rx_req;
    assign irq_tx_req = r_tx_req;

endmodule

// File: tb/tb_dl11_serial.sv
module tb_dl11_serial;
    import dl11_pkg::*;

    localparam int unsigned B    = 16;
    localparam logic [15:0] BASE = 16'o177560;
`ifdef DL11_MAINT_EN
    localparam logic [15:0] MAINT_BIT = 16'h0004;
`else
    localparam logic [15:0] MAINT_BIT = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] din = '0;
    logic        sync = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  wtbt = 2'b00;
    logic [15:0] dout;
    logic        ack, irq_rx_req, irq_tx_req, txd;
    logic        irq_rx_ack = 1'b0, irq_tx_ack = 1'b0;
    logic        rxd = 1'b1;

    always #5 clk = ~clk;

    dl11_serial #(
        .BAUD_DIV  (B),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_sys    (clk),
        .reset_n    (rst_n),
        .ce         (ce),
        .bus_addr   (addr),
        .bus_din    (din),
        .bus_sync   (sync),
        .bus_stb    (stb),
        .bus_we     (we),
        .bus_wtbt   (wtbt),
        .bus_dout   (dout),
        .bus_ack    (ack),
        .irq_rx_req (irq_rx_req),
        .irq_rx_ack (irq_rx_ack),
        .irq_tx_req (irq_tx_req),
        .irq_tx_ack (irq_tx_ack),
        .uart_rxd   (rxd),
        .uart_txd   (txd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit cap_en = 1'b0;
    bit cap_q[$];
    always @(negedge clk) if (cap_en) cap_q.push_back(txd);

    // Receiver reference model: flags and data as the CPU should see them.
    logic       m_done = 1'b0, m_ovr = 1'b0, m_frm = 1'b0;
    logic [7:0] m_data = 8'h00;

    typedef struct {
        bit          do_wr;
        logic [1:0]  wr_reg;
        logic [15:0] wr_data;
        logic [1:0]  wr_bt;
        logic [1:0]  rd_reg;
        logic [15:0] exp_rd;
        logic        exp_irq_tx;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_cycle(input bit wr, input logic [1:0] rg, input logic [15:0] wd,
                             input logic [1:0] bt, output logic [15:0] rd);
        int n;
        @(negedge clk);
        addr = BASE + {13'd0, rg, 1'b0};
        sync = 1'b1; we = wr; din = wd; wtbt = bt; stb = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ack && n < 20) begin @(negedge clk); n++; end
        if (!ack) check("ack_timeout", {31'd0, ack}, 32'd1);
        rd = dout;
        stb = 1'b0; sync = 1'b0; we = 1'b0;
        n = 0;
        @(negedge clk);
        while (ack && n < 20) begin @(negedge clk); n++; end
        if (ack) check("ack_release_timeout", {31'd0, ack}, 32'd0);
    endtask

    task automatic bus_rd(input logic [1:0] rg, output logic [15:0] rd);
        bus_cycle(1'b0, rg, 16'h0, 2'b00, rd);
    endtask

    task automatic bus_wr(input logic [1:0] rg, input logic [15:0] wd, input logic [1:0] bt);
        logic [15:0] unused_rd;
        bus_cycle(1'b1, rg, wd, bt, unused_rd);
    endtask

    task automatic rd_check(input string nm, input logic [1:0] rg, input logic [15:0] exp);
        logic [15:0] v;
        bus_rd(rg, v);
        check(nm, {16'd0, v}, {16'd0, exp});
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = f[i];
            repeat (B - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic model_rx(input logic [7:0] b, input bit stop_ok);
        if (m_done) m_ovr = 1'b1;
        m_data = b;
        if (!stop_ok) m_frm = 1'b1;
        m_done = 1'b1;
    endtask

    function automatic logic [15:0] model_rbuf();
        return {m_ovr | m_frm, m_ovr, m_frm, 5'b0, m_data};
    endfunction

    task automatic pulse_tx_ack();
        @(negedge clk); irq_tx_ack = 1'b1;
        @(negedge clk); irq_tx_ack = 1'b0;
        @(negedge clk);
    endtask

    // Checks a captured frame: start, 8 data LSB first, stop, each exactly B samples.
    task automatic check_tx_frame(input string nm, input logic [7:0] b);
        int s;
        logic [9:0] f;
        bit ok;
        f = {1'b1, b, 1'b0};
        s = -1;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (cap_q[i] == 1'b0) begin s = i; break; end
        end
        if (s < 0) begin
            check({nm, "_no_start"}, 32'd0, 32'd1);
        end else begin
            for (int i = 0; i < 10; i++) begin
                ok = 1'b1;
                for (int j = 0; j < int'(B); j++) begin
                    int idx;
                    idx = s + i * int'(B) + j;
                    if (idx >= cap_q.size() || cap_q[idx] != f[i]) ok = 1'b0;
                end
                check($sformatf("%s_bit%0d", nm, i), {31'd0, ok}, 32'd1);
            end
        end
    endtask

    task automatic tx_byte(input string nm, input logic [7:0] b, input logic [15:0] exp_busy,
                           input logic [15:0] exp_done);
        cap_q.delete();
        cap_en = 1'b1;
        bus_wr(REG_XBUF, {8'h00, b}, 2'b01);
        rd_check({nm, "_xcsr_busy"}, REG_XCSR, exp_busy);
        repeat (11 * B) @(negedge clk);
        cap_en = 1'b0;
        check_tx_frame(nm, b);
        rd_check({nm, "_xcsr_done"}, REG_XCSR, exp_done);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  b;
        bit          ok;

        vecs[0]  = '{1'b0, REG_XCSR, 16'h0000, 2'b00, REG_XCSR, 16'h0080, 1'b0};
        vecs[1]  = '{1'b0, REG_RCSR, 16'h0000, 2'b00, REG_RCSR, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, REG_RBUF, 16'h0000, 2'b00, REG_RBUF, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, REG_XBUF, 16'h0000, 2'b00, REG_XBUF, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, REG_RCSR, 16'hFFFF, 2'b01, REG_RCSR, 16'h0040, 1'b0};
        vecs[5]  = '{1'b1, REG_RCSR, 16'h0000, 2'b10, REG_RCSR, 16'h0040, 1'b0};
        vecs[6]  = '{1'b1, REG_RCSR, 16'h0000, 2'b01, REG_RCSR, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, REG_XCSR, 16'h00C0, 2'b01, REG_XCSR, 16'h00C0, 1'b1};
        vecs[8]  = '{1'b1, REG_XCSR, 16'h0000, 2'b01, REG_XCSR, 16'h0080, 1'b0};
        vecs[9]  = '{1'b1, REG_RBUF, 16'hFFFF, 2'b11, REG_RBUF, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, REG_XCSR, 16'h0004, 2'b01, REG_XCSR, 16'h0080 | MAINT_BIT, 1'b0};
        vecs[11] = '{1'b1, REG_XCSR, 16'h0000, 2'b01, REG_XCSR, 16'h0080, 1'b0};

        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state and register access table
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_irq", {30'd0, irq_rx_req, irq_tx_req}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) bus_wr(vecs[i].wr_reg, vecs[i].wr_data, vecs[i].wr_bt);
            rd_check($sformatf("vec%0d_rd", i), vecs[i].rd_reg, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq_tx", i), {31'd0, irq_tx_req}, {31'd0, vecs[i].exp_irq_tx});
        end

        // Access outside the window: no ack, no data
        @(negedge clk);
        addr = BASE + 16'd8; sync = 1'b1; stb = 1'b1; we = 1'b0;
        repeat (4) @(negedge clk);
        check("unsel_ack", {31'd0, ack}, 32'd0);
        check("unsel_dout", {16'd0, dout}, 32'd0);
        stb = 1'b0; sync = 1'b0;

        // ce gating of ack; read data is independent of ce
        @(negedge clk);
        ce = 1'b0;
        addr = BASE + 16'd4; sync = 1'b1; stb = 1'b1; we = 1'b0;
        repeat (4) @(negedge clk);
        check("ce_gated_ack", {31'd0, ack}, 32'd0);
        check("ce_gated_dout", {16'd0, dout}, 32'h0080);
        ce = 1'b1;
        @(negedge clk);
        check("ce_ack", {31'd0, ack}, 32'd1);
        stb = 1'b0; sync = 1'b0;
        repeat (3) @(negedge clk);

        // TX of 0x55 with interrupt handshake
        bus_wr(REG_XCSR, 16'h0040, 2'b01);
        check("tx_irq_ie_set", {31'd0, irq_tx_req}, 32'd1);
        pulse_tx_ack();
        check("tx_irq_acked", {31'd0, irq_tx_req}, 32'd0);
        tx_byte("tx55", 8'h55, 16'h0040, 16'h00C0);
        check("tx_irq_after_frame", {31'd0, irq_tx_req}, 32'd1);
        pulse_tx_ack();
        check("tx_irq_acked2", {31'd0, irq_tx_req}, 32'd0);
        bus_wr(REG_XCSR, 16'h0000, 2'b01);

        // XBUF write while busy is dropped
        cap_q.delete();
        cap_en = 1'b1;
        bus_wr(REG_XBUF, 16'h00F0, 2'b01);
        bus_wr(REG_XBUF, 16'h000F, 2'b01);
        repeat (11 * B) @(negedge clk);
        cap_en = 1'b0;
        check_tx_frame("tx_drop", 8'hF0);

        // Random TX bytes
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            tx_byte($sformatf("txr%0d", i), b, 16'h0000, 16'h0080);
        end

        // RX 0xA3
        send_frame(8'hA3, 1'b1);
        rd_check("rx_a3_rcsr", REG_RCSR, 16'h0080);
        rd_check("rx_a3_rbuf", REG_RBUF, 16'o000243);
        rd_check("rx_a3_rcsr_clr", REG_RCSR, 16'h0000);

        // Overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd_check("rx_ovr_rbuf", REG_RBUF, 16'o140042);
        rd_check("rx_ovr_rbuf_clr", REG_RBUF, 16'h0022);

        // Framing error and glitch rejection
        send_frame(8'h5A, 1'b0);
        rd_check("rx_frm_rbuf", REG_RBUF, 16'hA05A);
        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (3 * B) @(negedge clk);
        rd_check("rx_glitch_rcsr", REG_RCSR, 16'h0000);

        // RX interrupt
        bus_wr(REG_RCSR, 16'h0040, 2'b01);
        send_frame(8'h77, 1'b1);
        check("rx_irq_set", {31'd0, irq_rx_req}, 32'd1);
        rd_check("rx_irq_rbuf", REG_RBUF, 16'h0077);
        check("rx_irq_clr", {31'd0, irq_rx_req}, 32'd0);
        bus_wr(REG_RCSR, 16'h0000, 2'b01);

        // Random RX against the model
        for (int i = 0; i < 8; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok);
            model_rx(b, ok);
            if ($urandom_range(0, 1) == 1) begin
                rd_check($sformatf("rxr%0d_rbuf", i), REG_RBUF, model_rbuf());
                m_done = 1'b0; m_ovr = 1'b0; m_frm = 1'b0;
            end else begin
                rd_check($sformatf("rxr%0d_rcsr", i), REG_RCSR, {8'h00, m_done, 7'h00});
            end
        end
        rd_check("rxr_flush", REG_RBUF, model_rbuf());
        rd_check("rxr_rcsr_end", REG_RCSR, 16'h0000);

        // Reset in the middle of a TX frame
        bus_wr(REG_XBUF, 16'h0000, 2'b01);
        repeat (5 * B) @(negedge clk);
        check("midtx_line_low", {31'd0, txd}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midtx_reset_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("midtx_reset_xcsr", REG_XCSR, 16'h0080);
        check("midtx_reset_irq", {30'd0, irq_rx_req, irq_tx_req}, 32'd0);

`ifdef DL11_MAINT_EN
        // Internal loopback: line held idle, byte received
        bus_wr(REG_XCSR, 16'h0004, 2'b01);
        cap_q.delete();
        cap_en = 1'b1;
        bus_wr(REG_XBUF, 16'h003C, 2'b01);
        repeat (11 * B) @(negedge clk);
        cap_en = 1'b0;
        ok = 1'b1;
        foreach (cap_q[k]) if (cap_q[k] != 1'b1) ok = 1'b0;
        check("maint_txd_idle", {31'd0, ok}, 32'd1);
        rd_check("maint_rbuf", REG_RBUF, 16'h003C);
        bus_wr(REG_XCSR, 16'h0000, 2'b01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
